// File: rtl/oam_dma_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : oam_dma_ctrl
//  Description : Sprite DMA sequencer on the CPU bus. A CPU write to the DMA
//                register stalls the CPU and copies one 256-byte CPU page into
//                the PPU sprite RAM (OAM) through a dedicated OAM write port.
//                The OAM destination starts at the address last written to
//                the OAMADDR register and wraps within OAM.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    cpu_clk      in   1   CPU clock, the only clock
//    reset_n      in   1   asynchronous active-low reset
//    bus_addr     in  16   CPU bus address
//    bus_din      in   8   CPU write data
//    bus_wr       in   1   bus direction: 1 = read, 0 = write
//    odd_or_even  in   1   CPU cycle parity: 1 = odd cycle
//    mem_din      in   8   CPU-memory read data for the DMA read cycle
//    dma_hijack   out  1   DMA owns the CPU bus, CPU stalled
//    dma_addr     out 16   bus address driven while hijacked
//    dma_wr       out  1   bus direction while hijacked (always read)
//    oam_addr     out  8   OAM write address
//    oam_data     out  8   OAM write data
//    oam_we       out  1   OAM write strobe, one cycle per byte
//    dma_done     out  1   one-cycle pulse after the last OAM write
// ============================================================================
module oam_dma_ctrl #(
    parameter logic [15:0] DMA_REG_ADDR     = 16'h4014,
    parameter logic [15:0] OAMADDR_REG_ADDR = 16'h2003,
    parameter logic        ALIGN_EN         = 1'b1
) (
    input  logic        cpu_clk,
    input  logic        reset_n,
    input  logic [15:0] bus_addr,
    input  logic [7:0]  bus_din,
    input  logic        bus_wr,
    input  logic        odd_or_even,
    input  logic [7:0]  mem_din,
    output logic        dma_hijack,
    output logic [15:0] dma_addr,
    output logic        dma_wr,
    output logic [7:0]  oam_addr,
    output logic [7:0]  oam_data,
    output logic        oam_we,
    output logic        dma_done
);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_HALT  = 3'd1;
    localparam logic [2:0] c_ALIGN = 3'd2;
    localparam logic [2:0] c_READ  = 3'd3;
    localparam logic [2:0] c_WRITE = 3'd4;
    localparam logic [2:0] c_DONE  = 3'd5;

    logic [2:0] r_state;
    logic [2:0] w_next_state;
    logic [7:0] r_page;
    logic [7:0] r_oam_base;
    logic [7:0] r_idx;
    logic [7:0] r_data;

    logic w_bus_owned;
    logic w_trigger;
    logic w_oamaddr_wr;

    // The bus is ours from HALT through the last WRITE; the CPU's address
    // lines are meaningless then, so snooping is suppressed.
    assign w_bus_owned  = (r_state == c_HALT)  || (r_state == c_ALIGN) ||
                          (r_state == c_READ)  || (r_state == c_WRITE);
    assign w_trigger    = !w_bus_owned && (r_state == c_IDLE) &&
                          (bus_addr == DMA_REG_ADDR) && !bus_wr;
    assign w_oamaddr_wr = !w_bus_owned &&
                          (bus_addr == OAMADDR_REG_ADDR) && !bus_wr;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge cpu_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE:  if (w_trigger) w_next_state = c_HALT;
            // An even HALT cycle means the next cycle is odd; burn one more
            // dummy cycle so every READ lands on an even cycle.
            c_HALT:  w_next_state = (ALIGN_EN && !odd_or_even) ? c_ALIGN : c_READ;
            c_ALIGN: w_next_state = c_READ;
            c_READ:  w_next_state = c_WRITE;
            c_WRITE: w_next_state = (r_idx == 8'hFF) ? c_DONE : c_READ;
            c_DONE:  w_next_state = c_IDLE;
            default: w_next_state = c_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers: page, OAM base, byte index, read latch
    // ------------------------------------------------------------------
    always_ff @(posedge cpu_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_page     <= 8'h00;
            r_oam_base <= 8'h00;
            r_idx      <= 8'h00;
            r_data     <= 8'h00;
        end else begin
            if (w_oamaddr_wr) begin
                r_oam_base <= bus_din;
            end
            if (w_trigger) begin
                r_page <= bus_din;
                r_idx  <= 8'h00;
            end
            if (r_state == c_READ) begin
                r_data <= mem_din;
            end
            // idx stays at FF after the final byte; the next trigger clears it.
            if ((r_state == c_WRITE) && (r_idx != 8'hFF)) begin
                r_idx <= r_idx + 8'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output decode (registered state only, no bus_* feed-through)
    // ------------------------------------------------------------------
    always_comb begin
        dma_hijack = 1'b0;
        dma_addr   = 16'h0000;
        dma_wr     = 1'b1;
        oam_addr   = 8'h00;
        oam_data   = 8'h00;
        oam_we     = 1'b0;
        dma_done   = 1'b0;
        case (r_state)
            c_HALT, c_ALIGN: begin
                dma_hijack = 1'b1;
            end
            c_READ: begin
                dma_hijack = 1'b1;
                dma_addr   = {r_page, r_idx};
            end
            c_WRITE: begin
                dma_hijack = 1'b1;
                dma_addr   = {r_page, r_idx};
                oam_we     = 1'b1;
                oam_addr   = r_oam_base + r_idx;
                oam_data   = r_data;
            end
            c_DONE: begin
                dma_done = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_oam_dma_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_oam_dma_ctrl
//  Description : Scoreboard bench for oam_dma_ctrl. Two instances share the
//                bus: one with alignment enabled, one without.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_oam_dma_ctrl;

    logic        cpu_clk     = 1'b0;
    logic        reset_n     = 1'b0;
    logic [15:0] bus_addr    = 16'h0000;
    logic [7:0]  bus_din     = 8'h00;
    logic        bus_wr      = 1'b1;
    logic        odd_or_even = 1'b0;

    logic [7:0]  mem [0:65535];

    // Instance A: ALIGN_EN = 1
    logic [7:0]  mem_din;
    logic        dma_hijack;
    logic [15:0] dma_addr;
    logic        dma_wr;
    logic [7:0]  oam_addr;
    logic [7:0]  oam_data;
    logic        oam_we;
    logic        dma_done;

    // Instance B: ALIGN_EN = 0
    logic [7:0]  mem_din_b;
    logic        hij_b;
    logic [15:0] addr_b;
    logic        wr_b;
    logic [7:0]  oaddr_b;
    logic [7:0]  odata_b;
    logic        we_b;
    logic        done_b;

    assign mem_din   = mem[dma_addr];
    assign mem_din_b = mem[addr_b];

    oam_dma_ctrl #(.ALIGN_EN(1'b1)) u_dut (
        .cpu_clk(cpu_clk), .reset_n(reset_n), .bus_addr(bus_addr),
        .bus_din(bus_din), .bus_wr(bus_wr), .odd_or_even(odd_or_even),
        .mem_din(mem_din), .dma_hijack(dma_hijack), .dma_addr(dma_addr),
        .dma_wr(dma_wr), .oam_addr(oam_addr), .oam_data(oam_data),
        .oam_we(oam_we), .dma_done(dma_done)
    );

    oam_dma_ctrl #(.ALIGN_EN(1'b0)) u_dut_noalign (
        .cpu_clk(cpu_clk), .reset_n(reset_n), .bus_addr(bus_addr),
        .bus_din(bus_din), .bus_wr(bus_wr), .odd_or_even(odd_or_even),
        .mem_din(mem_din_b), .dma_hijack(hij_b), .dma_addr(addr_b),
        .dma_wr(wr_b), .oam_addr(oaddr_b), .oam_data(odata_b),
        .oam_we(we_b), .dma_done(done_b)
    );

    always #5 cpu_clk = ~cpu_clk;

    // Cycle parity toggles shortly after every rising edge.
    initial begin
        forever begin
            @(posedge cpu_clk);
            #1;
            odd_or_even = ~odd_or_even;
        end
    end

    int total = 0;
    int bad   = 0;

    // Scoreboard: {src_addr[15:0], oam_addr[7:0], oam_data[7:0]} per write,
    // and expected hijack length per DMA.
    logic [31:0] exp_q [$];
    int          len_q [$];
    logic [7:0]  model_base = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Monitor for instance A
    // ------------------------------------------------------------------
    int          hij_cnt  = 0;
    int          we_cnt   = 0;
    logic        prev_par = 1'b0;
    logic [31:0] e;

    always @(negedge cpu_clk) begin
        if (!reset_n) begin
            hij_cnt = 0;
            we_cnt  = 0;
        end else begin
            if (dma_hijack) begin
                hij_cnt++;
                check("dma_wr_read", {31'd0, dma_wr}, 32'd1);
            end
            if (oam_we) begin
                if (we_cnt == 0) check("first_read_even", {31'd0, prev_par}, 32'd0);
                we_cnt++;
                if (exp_q.size() == 0) begin
                    check("unexpected_oam_we", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("src_addr", {16'd0, dma_addr}, {16'd0, e[31:16]});
                    check("oam_addr", {24'd0, oam_addr}, {24'd0, e[15:8]});
                    check("oam_data", {24'd0, oam_data}, {24'd0, e[7:0]});
                end
            end
            if (dma_done) begin
                if (len_q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    check("hijack_len", hij_cnt, len_q.pop_front());
                end
                check("oam_we_count", we_cnt, 32'd256);
                hij_cnt = 0;
                we_cnt  = 0;
            end
        end
        prev_par = odd_or_even;
    end

    // ------------------------------------------------------------------
    // Monitor for instance B (no alignment: always 513 cycles)
    // ------------------------------------------------------------------
    int hij_b_cnt  = 0;
    int we_b_cnt   = 0;
    int done_b_cnt = 0;

    always @(negedge cpu_clk) begin
        if (!reset_n) begin
            hij_b_cnt = 0;
            we_b_cnt  = 0;
        end else begin
            if (hij_b) hij_b_cnt++;
            if (we_b)  we_b_cnt++;
            if (done_b) begin
                check("noalign_hijack_len", hij_b_cnt, 32'd513);
                check("noalign_we_count", we_b_cnt, 32'd256);
                done_b_cnt++;
                hij_b_cnt = 0;
                we_b_cnt  = 0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus tasks
    // ------------------------------------------------------------------
    // halt_par is the parity the HALT cycle will see (the cycle after the
    // trigger edge).
    task automatic trigger(input logic [7:0] page, input logic halt_par);
        int guard = 0;
        logic [7:0] i8;
        @(negedge cpu_clk);
        while ((odd_or_even == halt_par) && (guard < 8)) begin
            @(negedge cpu_clk);
            guard++;
        end
        bus_addr = 16'h4014;
        bus_din  = page;
        bus_wr   = 1'b0;
        len_q.push_back(halt_par ? 513 : 514);
        for (int i = 0; i < 256; i++) begin
            i8 = 8'(i);
            exp_q.push_back({page, i8, model_base + i8, mem[{page, i8}]});
        end
        @(negedge cpu_clk);
        bus_addr = 16'h0000;
        bus_din  = 8'h00;
        bus_wr   = 1'b1;
    endtask

    task automatic write_oamaddr(input logic [7:0] v);
        @(negedge cpu_clk);
        bus_addr = 16'h2003;
        bus_din  = v;
        bus_wr   = 1'b0;
        model_base = v;
        @(negedge cpu_clk);
        bus_addr = 16'h0000;
        bus_din  = 8'h00;
        bus_wr   = 1'b1;
    endtask

    task automatic wait_done();
        logic got = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge cpu_clk);
            if (dma_done) begin
                got = 1'b1;
                break;
            end
        end
        check("done_timeout", {31'd0, got}, 32'd1);
        repeat (4) @(negedge cpu_clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int a = 0; a < 65536; a++) begin
            mem[a] = 8'(a) * 8'd3 + 8'(a >> 8) + 8'h11;
        end
        for (int i = 0; i < 256; i++) begin
            mem[16'h0200 + i] = 8'(i) ^ 8'h5A;
        end

        // Reset state
        repeat (3) @(negedge cpu_clk);
        check("rst_hijack",   {31'd0, dma_hijack}, 32'd0);
        check("rst_dma_wr",   {31'd0, dma_wr},     32'd1);
        check("rst_oam_we",   {31'd0, oam_we},     32'd0);
        check("rst_done",     {31'd0, dma_done},   32'd0);
        check("rst_dma_addr", {16'd0, dma_addr},   32'd0);
        check("rst_oam_addr", {24'd0, oam_addr},   32'd0);
        check("rst_oam_data", {24'd0, oam_data},   32'd0);
        reset_n = 1'b1;
        repeat (4) @(negedge cpu_clk);

        // Basic copy, HALT on an odd cycle: no ALIGN, 513 cycles
        trigger(8'h02, 1'b1);
        wait_done();

        // HALT on an even cycle: ALIGN inserted (514) on A only
        trigger(8'h02, 1'b0);
        wait_done();

        // Retrigger and OAMADDR writes while hijacked are ignored
        trigger(8'h02, 1'b1);
        repeat (20) @(negedge cpu_clk);
        bus_addr = 16'h4014; bus_din = 8'h07; bus_wr = 1'b0;
        @(negedge cpu_clk);
        bus_addr = 16'h2003; bus_din = 8'h55; bus_wr = 1'b0;
        @(negedge cpu_clk);
        bus_addr = 16'h0000; bus_din = 8'h00; bus_wr = 1'b1;
        wait_done();

        // OAM base wrap
        write_oamaddr(8'hF0);
        trigger(8'h03, 1'b0);
        wait_done();

        // Page FF stays in page; OAM base still F0 from before
        trigger(8'hFF, 1'b1);
        wait_done();

        // Reset in the middle of a DMA
        trigger(8'h02, 1'b1);
        for (int c = 0; c < 1000; c++) begin
            @(negedge cpu_clk);
            #1;
            if (we_cnt >= 100) break;
        end
        check("reached_100_writes", {31'd0, (we_cnt >= 100)}, 32'd1);
        reset_n = 1'b0;
        #1;
        check("midrst_hijack", {31'd0, dma_hijack}, 32'd0);
        check("midrst_oam_we", {31'd0, oam_we},     32'd0);
        check("midrst_done",   {31'd0, dma_done},   32'd0);
        exp_q.delete();
        len_q.delete();
        model_base = 8'h00;
        repeat (3) @(negedge cpu_clk);
        reset_n = 1'b1;
        repeat (5) begin
            @(negedge cpu_clk);
            check("no_done_after_reset", {31'd0, dma_done}, 32'd0);
        end

        // Fresh DMA after reset uses OAM base 0
        trigger(8'h02, 1'b0);
        wait_done();

        check("exp_queue_empty", exp_q.size(), 32'd0);
        check("len_queue_empty", len_q.size(), 32'd0);
        check("noalign_done_count", done_b_cnt, 32'd6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
